stack_rr_scheduler: RTL and testbench

//  Shares one DW_stack LIFO between NREQ requesters. Each requester issues push or pop.
//  The block applies round-robin arbitration and blocks illegal ops (push on full, pop on empty).
//  It returns a registered per-op response and offers a flush sequence that drains the stack.
//  It sits between client logic and the DW_stack instance and is the only driver of its request pins.

---
 rtl/stack_rr_scheduler_if.sv | 29 ++
 rtl/stack_rr_scheduler.sv | 153 +++++++++++++++
 tb/tb_stack_rr_scheduler.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_rr_scheduler_if.sv
// Requester-side bundle of the shared-stack scheduler: op requests in, grant and response out.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until they see their gnt bit.
interface stack_rr_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       op_push;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;

  // Client side: raises requests, watches grants and responses.
  modport master (
    output req, op_push, wdata,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // Scheduler side: arbitrates requests, drives grants and responses.
  modport slave (
    input  req, op_push, wdata,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_rr_scheduler.sv
// Round-robin arbiter sharing one LIFO between NREQ requesters, with illegal-op blocking and a drain (flush) mode.
// Latency: grant and stack strobe are combinational in the issue cycle; response registered one cycle later.
// Backpressure: losers keep req high and wait; flush blocks all grants until the stack reports empty.
module stack_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stack_rr_scheduler_if.slave  cli,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 sticky_err,
  output logic                 stk_push_n,
  output logic                 stk_pop_n,
  output logic [WIDTH-1:0]     stk_din,
  input  logic                 stk_empty,
  input  logic                 stk_full,
  input  logic                 stk_error,
  input  logic [WIDTH-1:0]     stk_dout
);

  localparam int              PW     = $clog2(NREQ);
  localparam logic [PW:0]     NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0]   LAST   = PW'(NREQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    winner;
  logic             found;
  logic [PW:0]      cand;
  logic             grant;
  logic             legal;
  logic             is_push;
  logic [WIDTH-1:0] wd [NREQ];

  // Unpack the flat write-data bus into one word per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_wd
    assign wd[g] = cli.wdata[g*WIDTH +: WIDTH];
  end

  // Pick the first active requester at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!found && cli.req[cand[PW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

  // Next-state, grant and stack-strobe decode; flush takes priority over any request in IDLE.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    legal      = 1'b0;
    is_push    = 1'b0;
    cli.gnt    = '0;
    stk_push_n = 1'b1;
    stk_pop_n  = 1'b1;
    stk_din    = '0;
    flush_busy = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = FLUSH;
        end else if (found) begin
          grant           = 1'b1;
          cli.gnt[winner] = 1'b1;
          is_push         = cli.op_push[winner];
          // A rejected op still consumes the grant but never touches the stack.
          legal           = is_push ? !stk_full : !stk_empty;
          if (legal && is_push) begin
            stk_push_n = 1'b0;
            stk_din    = wd[winner];
          end else if (legal) begin
            stk_pop_n = 1'b0;
          end
        end
      end
      FLUSH: begin
        flush_busy = 1'b1;
        if (!stk_empty) begin
          stk_pop_n = 1'b0;
        end else begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and round-robin pointer; the pointer advances past every granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        rr_ptr <= (winner == LAST) ? '0 : winner + 1'b1;
      end
    end
  end

  // One-cycle registered response; data is the top of stack seen in the grant cycle of a legal pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cli.rsp_valid <= 1'b0;
      cli.rsp_id    <= '0;
      cli.rsp_data  <= '0;
      cli.rsp_err   <= 1'b0;
    end else begin
      cli.rsp_valid <= grant;
      cli.rsp_id    <= grant ? IDW'(winner) : '0;
      cli.rsp_data  <= (grant && legal && !is_push) ? stk_dout : '0;
      cli.rsp_err   <= grant && !legal;
    end
  end

  // Latch stack errors until a drain completes; a fresh error in the completion cycle still sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_err <= 1'b0;
    end else begin
      sticky_err <= stk_error || (sticky_err && !flush_done);
    end
  end

  // The stack must never see push and pop together, and at most one requester is granted.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(!stk_push_n && !stk_pop_n));
  a_gnt_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(cli.gnt));

endmodule

// File: tb/tb_stack_rr_scheduler.sv
// Bench for the shared-stack round-robin scheduler: directed scenarios then randomized traffic against a queue model.
// Latency: checks grant/strobes in the issue cycle and responses one cycle later.
// Backpressure: random requesters hold req until their modelled grant.
module tb_stack_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush_req = 1'b0;
  logic             flush_busy;
  logic             flush_done;
  logic             sticky_err;
  logic             stk_push_n;
  logic             stk_pop_n;
  logic [WIDTH-1:0] stk_din;
  logic             stk_empty = 1'b1;
  logic             stk_full = 1'b0;
  logic             stk_error = 1'b0;
  logic [WIDTH-1:0] stk_dout = '0;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  stack_rr_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) cli_if ();

  stack_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cli        (cli_if),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .sticky_err (sticky_err),
    .stk_push_n (stk_push_n),
    .stk_pop_n  (stk_pop_n),
    .stk_din    (stk_din),
    .stk_empty  (stk_empty),
    .stk_full   (stk_full),
    .stk_error  (stk_error),
    .stk_dout   (stk_dout)
  );

  // Stand-in for the attached LIFO: reacts only to the strobes the scheduler drives.
  logic [WIDTH-1:0] env_q [$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_q.delete();
    end else begin
      if (!stk_push_n && env_q.size() < DEPTH) env_q.push_back(stk_din);
      else if (!stk_pop_n && env_q.size() > 0) void'(env_q.pop_back());
    end
    stk_empty <= (env_q.size() == 0);
    stk_full  <= (env_q.size() == DEPTH);
    stk_dout  <= (env_q.size() > 0) ? env_q[$] : '0;
  end

  // Reference model state
  int               m_state;   // 0 = idle, 1 = draining
  int               m_ptr;
  logic [WIDTH-1:0] m_stk [$];
  bit               m_sticky;
  bit               e_rv;
  bit               e_err;
  int               e_id;
  logic [WIDTH-1:0] e_data;
  int               last_w;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_ptr    = 0;
    m_stk.delete();
    m_sticky = 0;
    e_rv     = 0;
    e_err    = 0;
    e_id     = 0;
    e_data   = '0;
    last_w   = -1;
  endtask

  // One cycle of the model: checks the DUT then advances the model state.
  task automatic model_cycle();
    logic [NREQ-1:0]  rq    = cli_if.req;
    logic [NREQ-1:0]  xg    = '0;
    logic             xpush = 1'b1;
    logic             xpop  = 1'b1;
    logic             xbusy = 1'b0;
    logic             xdone = 1'b0;
    logic [WIDTH-1:0] xdin  = '0;
    bit               nrv   = 0;
    bit               nerr  = 0;
    int               nid   = 0;
    logic [WIDTH-1:0] ndata = '0;
    int               nstate = m_state;
    int               j;
    last_w = -1;

    check_val("rsp_valid", cli_if.rsp_valid, e_rv);
    check_val("rsp_id",    cli_if.rsp_id,    e_id);
    check_val("rsp_data",  cli_if.rsp_data,  e_data);
    check_val("rsp_err",   cli_if.rsp_err,   e_err);
    check_val("sticky",    sticky_err,       m_sticky);

    if (m_state == 0) begin
      if (flush_req) begin
        nstate = 1;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (rq[j[1:0]]) begin
            last_w = j;
            break;
          end
        end
        if (last_w >= 0) begin
          xg[last_w] = 1'b1;
          nrv   = 1;
          nid   = last_w;
          m_ptr = (last_w + 1) % NREQ;
          if (cli_if.op_push[last_w]) begin
            if (m_stk.size() < DEPTH) begin
              xpush = 1'b0;
              xdin  = cli_if.wdata[last_w*WIDTH +: WIDTH];
              m_stk.push_back(xdin);
            end else begin
              nerr = 1;
            end
          end else begin
            if (m_stk.size() > 0) begin
              xpop  = 1'b0;
              ndata = m_stk.pop_back();
            end else begin
              nerr = 1;
            end
          end
        end
      end
    end else begin
      xbusy = 1'b1;
      if (m_stk.size() > 0) begin
        xpop = 1'b0;
        void'(m_stk.pop_back());
      end else begin
        xdone  = 1'b1;
        nstate = 0;
      end
    end

    check_val("gnt",        cli_if.gnt, xg);
    check_val("push_n",     stk_push_n, xpush);
    check_val("pop_n",      stk_pop_n,  xpop);
    check_val("flush_busy", flush_busy, xbusy);
    check_val("flush_done", flush_done, xdone);
    if (!xpush) check_val("stk_din", stk_din, xdin);

    m_sticky = stk_error || (m_sticky && !xdone);
    e_rv     = nrv;
    e_err    = nerr;
    e_id     = nid;
    e_data   = ndata;
    m_state  = nstate;
  endtask

  task automatic half_a();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cli_if.req     = '0;
    cli_if.op_push = '0;
    cli_if.wdata   = '0;
    flush_req      = 1'b0;
    stk_error      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    half_b();
  endtask

  // Single-cycle op from requester r while no one else is requesting.
  task automatic do_op(input int r, input bit push, input logic [WIDTH-1:0] d);
    cli_if.req     = '0;
    cli_if.op_push = '0;
    cli_if.req[r]     = 1'b1;
    cli_if.op_push[r] = push;
    cli_if.wdata[r*WIDTH +: WIDTH] = d;
    half_a();
    half_b();
    cli_if.req = '0;
  endtask

  // Start a drain and return the number of cycles spent in the drain state.
  task automatic do_flush(output int n);
    bit d;
    n = 0;
    flush_req = 1'b1;
    half_a();
    half_b();
    flush_req = 1'b0;
    d = 0;
    for (int k = 0; k < 20 && !d; k++) begin
      half_a();
      d = flush_done;
      n++;
      half_b();
    end
    if (!d) check_val("flush_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int pops;
    int dones;
    bit g;
    logic [NREQ-1:0]       pend;
    logic [NREQ-1:0]       pop_t;
    logic [NREQ*WIDTH-1:0] pdat;

    #1;
    do_reset();

    // Reset state with no requests.
    for (int k = 0; k < 3; k++) begin
      half_a();
      check_val("t1_gnt",    cli_if.gnt, 0);
      check_val("t1_rv",     cli_if.rsp_valid, 0);
      check_val("t1_push_n", stk_push_n, 1);
      check_val("t1_pop_n",  stk_pop_n, 1);
      check_val("t1_sticky", sticky_err, 0);
      half_b();
    end

    // All four requesters push: grants rotate 0,1,2,3,0.
    cli_if.req     = 4'b1111;
    cli_if.op_push = 4'b1111;
    for (int i = 0; i < NREQ; i++) cli_if.wdata[i*WIDTH +: WIDTH] = 8'hA0 + WIDTH'(i);
    for (int k = 0; k < 5; k++) begin
      half_a();
      check_val("t2_gnt", cli_if.gnt, 32'd1 << (k % 4));
      if (k > 0) begin
        check_val("t2_rsp_id",  cli_if.rsp_id, (k - 1) % 4);
        check_val("t2_rsp_err", cli_if.rsp_err, 0);
      end
      half_b();
    end
    clear_inputs();
    half_a();
    half_b();

    // LIFO order through the arbiter.
    do_reset();
    do_op(0, 1, 8'h11);
    do_op(0, 1, 8'h22);
    do_op(2, 0, 8'h00);
    half_a();
    check_val("t3_id",    cli_if.rsp_id, 2);
    check_val("t3_data1", cli_if.rsp_data, 8'h22);
    half_b();
    do_op(1, 0, 8'h00);
    half_a();
    check_val("t3_data2", cli_if.rsp_data, 8'h11);
    half_b();

    // Push on full and pop on empty are rejected.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_op(0, 1, WIDTH'(i + 1));
    cli_if.req = 4'b0010; cli_if.op_push = 4'b0010; cli_if.wdata = {NREQ{8'hFF}};
    half_a();
    check_val("t4_full_gnt",    cli_if.gnt, 4'b0010);
    check_val("t4_full_push_n", stk_push_n, 1);
    half_b();
    clear_inputs();
    half_a();
    check_val("t4_full_err", cli_if.rsp_err, 1);
    half_b();
    do_flush(n);
    check_val("t4_drain_len", n, DEPTH + 1);
    do_op(3, 0, 8'h00);
    half_a();
    check_val("t4_empty_err",  cli_if.rsp_err, 1);
    check_val("t4_empty_data", cli_if.rsp_data, 0);
    half_b();
    do_flush(n);
    check_val("t4_flush_empty_len", n, 1);

    // Flush preempts a waiting requester, which is served right after the drain.
    for (int i = 0; i < 3; i++) do_op(1, 1, WIDTH'(8'h30 + i));
    cli_if.req = 4'b0001; cli_if.op_push = 4'b0001; cli_if.wdata = {NREQ{8'h55}};
    flush_req = 1'b1;
    pops = 0; dones = 0; g = 0; n = 0;
    for (int k = 0; k < 12 && !g; k++) begin
      half_a();
      n++;
      g = cli_if.gnt[0];
      if (!stk_pop_n) pops++;
      if (flush_done) dones++;
      half_b();
      flush_req = 1'b0;
    end
    cli_if.req = '0;
    check_val("t5_grant_cycle", n, 6);
    check_val("t5_pops",  pops, 3);
    check_val("t5_dones", dones, 1);

    // Sticky error holds until a drain completes.
    stk_error = 1'b1;
    half_a();
    half_b();
    stk_error = 1'b0;
    for (int k = 0; k < 3; k++) begin half_a(); half_b(); end
    check_val("t6_sticky_set", sticky_err, 1);
    do_flush(n);
    check_val("t6_sticky_clr", sticky_err, 0);

    // Reset in the middle of a drain aborts it at once.
    for (int i = 0; i < 3; i++) do_op(2, 1, WIDTH'(8'h60 + i));
    flush_req = 1'b1;
    half_a();
    half_b();
    flush_req = 1'b0;
    half_a();
    half_b();
    #1;
    check_val("t6_busy_before", flush_busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_busy_rst", flush_busy, 0);
    check_val("t6_done_rst", flush_done, 0);
    check_val("t6_pop_rst",  stk_pop_n, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    half_b();
    do_op(3, 1, 8'h77);
    half_a();
    check_val("t6_after_rst_id",  cli_if.rsp_id, 3);
    check_val("t6_after_rst_err", cli_if.rsp_err, 0);
    half_b();

    // Randomized traffic: requesters hold their op until the model grants them.
    pend = '0; pop_t = '0; pdat = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!pend[r] && ($urandom % 3 == 0)) begin
          pend[r]  = 1'b1;
          pop_t[r] = ($urandom % 100) < 45;
          pdat[r*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      cli_if.req     = pend;
      cli_if.op_push = ~pop_t;
      cli_if.wdata   = pdat;
      flush_req      = ($urandom % 40 == 0);
      stk_error      = ($urandom % 100 == 0);
      half_a();
      if (last_w >= 0) pend[last_w] = 1'b0;
      half_b();
    end
    clear_inputs();
    half_a();
    half_b();
    half_a();
    half_b();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
